// File: rtl/bisuo_win_ctrl_if.sv
// bisuo_win_ctrl_if: trigger, config, sample and status signals of the blanking controller
interface bisuo_win_ctrl_if #(parameter int DW = 32);
    logic          prt_pulse;
    logic          cfg_sclr;
    logic [7:0]    cfg_st;
    logic [7:0]    cfg_width;
    logic          din_valid;
    logic [DW-1:0] din;
    logic          dout_valid;
    logic [DW-1:0] dout;
    logic          blank_active;
    logic          win_done;
    logic [7:0]    overrun_cnt;
    logic [15:0]   prt_cnt;
    modport master (
        output prt_pulse, cfg_sclr, cfg_st, cfg_width, din_valid, din,
        input  dout_valid, dout, blank_active, win_done, overrun_cnt, prt_cnt
    );
    modport slave (
        input  prt_pulse, cfg_sclr, cfg_st, cfg_width, din_valid, din,
        output dout_valid, dout, blank_active, win_done, overrun_cnt, prt_cnt
    );
endinterface

// File: rtl/bisuo_win_ctrl.sv
// bisuo_win_ctrl: per-pulse blanking window and data gate; BISUO_STAT_EN adds the prt_pulse counter
module bisuo_win_ctrl #(
    parameter int DW        = 32,
    parameter int UNIT_LOG2 = 4
) (
    input logic             clk,
    input logic             sys_rst,
    bisuo_win_ctrl_if.slave bus
);
    localparam int CW = 8 + UNIT_LOG2;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, DELAY, BLANK, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] st_len_q, wid_len_q;
    logic [CW-1:0] st_new, wid_new;
    logic          sclr_q;
    logic          done_d, done_q;
    logic          blank_q;
    logic          dv_q;
    logic [DW-1:0] dout_q;
    logic [7:0]    ovr_q;
    logic          ovr_inc;

    // window lengths in samples, taken straight from the host settings at trigger time
    assign st_new  = {bus.cfg_st, {UNIT_LOG2{1'b0}}};
    assign wid_new = {bus.cfg_width, {UNIT_LOG2{1'b0}}};
    assign ovr_inc = bus.prt_pulse && (state_q == DELAY || state_q == BLANK) && ovr_q != 8'hFF;
    assign cnt_d   = (bus.prt_pulse || state_d != state_q) ? '0 : cnt_q + {{(CW-1){1'b0}}, bus.din_valid};

    // next state: a trigger always restarts from the new settings; otherwise count samples to the edges
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (bus.prt_pulse) begin
            state_d = |st_new ? DELAY : (|wid_new ? BLANK : DONE);
            done_d  = ~|st_new && ~|wid_new;
        end else if (bus.din_valid && state_q == DELAY && cnt_q == st_len_q - ONE) begin
            state_d = |wid_len_q ? BLANK : DONE;
            done_d  = ~|wid_len_q;
        end else if (bus.din_valid && state_q == BLANK && cnt_q == wid_len_q - ONE) begin
            state_d = DONE;
            done_d  = 1'b1;
        end
    end

    // state, shadows, counters and registered outputs; gating uses the state the sample arrives in
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            st_len_q  <= '0;
            wid_len_q <= '0;
            sclr_q    <= 1'b0;
            done_q    <= 1'b0;
            blank_q   <= 1'b0;
            dv_q      <= 1'b0;
            dout_q    <= '0;
            ovr_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            blank_q <= state_d == BLANK;
            dv_q    <= bus.din_valid;
            if (bus.prt_pulse) begin
                st_len_q  <= st_new;
                wid_len_q <= wid_new;
                sclr_q    <= bus.cfg_sclr;
            end
            if (bus.din_valid)
                dout_q <= (state_q == BLANK && sclr_q) ? '0 : bus.din;
            if (ovr_inc)
                ovr_q <= ovr_q + 8'd1;
        end
    end

    assign bus.dout_valid   = dv_q;
    assign bus.dout         = dout_q;
    assign bus.blank_active = blank_q;
    assign bus.win_done     = done_q;
    assign bus.overrun_cnt  = ovr_q;

`ifdef BISUO_STAT_EN
    logic [15:0] prt_cnt_q;

    // free-running trigger count, wraps naturally
    always_ff @(posedge clk) begin
        if (sys_rst)
            prt_cnt_q <= '0;
        else if (bus.prt_pulse)
            prt_cnt_q <= prt_cnt_q + 16'd1;
    end

    assign bus.prt_cnt = prt_cnt_q;
`else
    assign bus.prt_cnt = '0;
`endif
endmodule

// File: tb/tb_bisuo_win_ctrl.sv
// tb_bisuo_win_ctrl: directed scoreboard bench for the blanking window controller (UNIT_LOG2=2)
module tb_bisuo_win_ctrl;
    typedef struct packed {
        logic [31:0] d;
        logic        b;
        logic        w;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;
    int   base;
    exp_t sb[$];
    exp_t e;

    bisuo_win_ctrl_if #(.DW(32)) bus();

    bisuo_win_ctrl #(.DW(32), .UNIT_LOG2(2)) dut (
        .clk(clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // monitor: every presented sample is matched against the oldest expected entry
    always @(negedge clk) begin
        if (bus.win_done === 1'b1) n_done++;
        if (!sys_rst && bus.dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: unexpected sample dout=%h", bus.dout);
            end else begin
                e = sb.pop_front();
                chk("dout", bus.dout, e.d);
                chk("blank_active", 32'(bus.blank_active), 32'(e.b));
                chk("win_done", 32'(bus.win_done), 32'(e.w));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] st, input logic [7:0] w, input logic s);
        bus.cfg_st = st;
        bus.cfg_width = w;
        bus.cfg_sclr = s;
        bus.prt_pulse = 1'b1;
        tick();
        bus.prt_pulse = 1'b0;
    endtask

    // samples a..b with din = index; s/w are window start/width in samples
    task automatic run(input int a, input int b, input int s, input int w, input bit sclr);
        for (int k = a; k <= b; k++) begin
            exp_t x;
            x.d = (sclr && k >= s && k < s + w) ? 32'd0 : 32'(k);
            x.b = k >= s - 1 && k < s + w - 1;
            x.w = k == s + w - 1;
            sb.push_back(x);
            bus.din_valid = 1'b1;
            bus.din = 32'(k);
            tick();
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic drain(input string n);
        repeat (3) tick();
        chk(n, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        bus.prt_pulse = 1'b0;
        bus.cfg_sclr = 1'b0;
        bus.cfg_st = 8'd0;
        bus.cfg_width = 8'd0;
        bus.din_valid = 1'b0;
        bus.din = 32'd0;
        tick();
        tick();
        chk("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_blank", 32'(bus.blank_active), 32'd0);
        chk("rst_win_done", 32'(bus.win_done), 32'd0);
        chk("rst_overrun", 32'(bus.overrun_cnt), 32'd0);
        chk("rst_prt_cnt", 32'(bus.prt_cnt), 32'd0);
        sys_rst = 1'b0;
        tick();

        base = n_done;
        pulse(8'd2, 8'd1, 1'b1);
        run(0, 15, 8, 4, 1);
        drain("t1_drain");
        chk("t1_done_count", 32'(n_done - base), 32'd1);
        chk("t1_dout_hold", bus.dout, 32'd15);

        base = n_done;
        pulse(8'd2, 8'd1, 1'b0);
        run(0, 15, 8, 4, 0);
        drain("t2_drain");
        chk("t2_done_count", 32'(n_done - base), 32'd1);

        base = n_done;
        pulse(8'd0, 8'd0, 1'b1);
        chk("t3_win_done", 32'(bus.win_done), 32'd1);
        chk("t3_blank", 32'(bus.blank_active), 32'd0);
        run(0, 5, 0, 0, 1);
        drain("t3_drain");
        chk("t3_done_count", 32'(n_done - base), 32'd1);

        base = n_done;
        pulse(8'd2, 8'd1, 1'b1);
        run(0, 9, 8, 4, 1);
        pulse(8'd2, 8'd1, 1'b1);
        chk("t4_overrun", 32'(bus.overrun_cnt), 32'd1);
        chk("t4_no_done", 32'(n_done - base), 32'd0);
        run(0, 15, 8, 4, 1);
        drain("t4_drain");
        chk("t4_done_count", 32'(n_done - base), 32'd1);
        for (int i = 0; i < 300; i++) pulse(8'd2, 8'd1, 1'b1);
        tick();
        chk("t4_overrun_sat", 32'(bus.overrun_cnt), 32'd255);

        base = n_done;
        pulse(8'd2, 8'd1, 1'b1);
        run(0, 3, 8, 4, 1);
        bus.cfg_st = 8'd5;
        run(4, 15, 8, 4, 1);
        drain("t5a_drain");
        pulse(8'd5, 8'd1, 1'b1);
        run(0, 25, 20, 4, 1);
        drain("t5b_drain");
        chk("t5_done_count", 32'(n_done - base), 32'd2);
        chk("t5_overrun_hold", 32'(bus.overrun_cnt), 32'd255);

        base = n_done;
        pulse(8'd0, 8'd1, 1'b1);
        chk("t6_blank", 32'(bus.blank_active), 32'd1);
        run(0, 1, 0, 4, 1);
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("t6_dout_valid", 32'(bus.dout_valid), 32'd0);
        chk("t6_dout", bus.dout, 32'd0);
        chk("t6_blank_rst", 32'(bus.blank_active), 32'd0);
        chk("t6_win_done", 32'(bus.win_done), 32'd0);
        chk("t6_overrun", 32'(bus.overrun_cnt), 32'd0);
        chk("t6_prt_cnt", 32'(bus.prt_cnt), 32'd0);
        chk("t6_sb", 32'(sb.size()), 32'd0);
        tick();
        tick();
        chk("t6_no_done", 32'(n_done - base), 32'd0);
        pulse(8'd0, 8'd0, 1'b0);
        pulse(8'd0, 8'd0, 1'b0);
        pulse(8'd0, 8'd0, 1'b0);
`ifdef BISUO_STAT_EN
        chk("t6_prt_cnt3", 32'(bus.prt_cnt), 32'd3);
`else
        chk("t6_prt_cnt3", 32'(bus.prt_cnt), 32'd0);
`endif
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
